// File: rtl/follower_lane.sv
`default_nettype none
// ============================================================================
// Module   : follower_lane
// Brief    : Scrolling obstacle lane with a bouncing car, wrap/respawn and a
//            sticky collision flag. Define FOLLOWER_LANE_LFSR_EN for an
//            LFSR-randomised respawn position and direction.
// Revision : 1.0 - initial release
// ============================================================================
module follower_lane #(
  parameter int        MOVE_AMT      = 2,
  parameter int        SCREEN_HEIGHT = 480,
  parameter int        SCREEN_WIDTH  = 640,
  parameter int        INIT_Y        = 0,
  parameter int        CAR_W         = 32,
  parameter int        CAR_H         = 16,
  parameter int        PLAYER_W      = 16,
  parameter int        PLAYER_H      = 16,
  parameter int        CAR_SPEED     = 3,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_followers,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] lane_y,
  output logic [9:0] car_x,
  output logic       car_dir,
  output logic       respawned,
  output logic       hit
);

  localparam logic [10:0] c_move   = 11'(MOVE_AMT);
  localparam logic [10:0] c_height = 11'(SCREEN_HEIGHT);
  localparam logic [9:0]  c_x_max  = 10'(SCREEN_WIDTH - CAR_W);
  localparam logic [9:0]  c_speed  = 10'(CAR_SPEED);
  localparam logic [9:0]  c_init_y = 10'(INIT_Y);
  localparam logic [10:0] c_car_w  = 11'(CAR_W);
  localparam logic [10:0] c_car_h  = 11'(CAR_H);
  localparam logic [10:0] c_ply_w  = 11'(PLAYER_W);
  localparam logic [10:0] c_ply_h  = 11'(PLAYER_H);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RESPAWN = 2'd1,
    ST_HIT     = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_lane_y, w_lane_y_nxt;
  logic [9:0] r_car_x, w_car_x_nxt;
  logic       r_car_dir, w_car_dir_nxt;
  logic       r_respawned, w_respawned_nxt;
  logic       r_hit, w_hit_nxt;
  logic       r_pend, w_pend_nxt;

  logic [10:0] w_lane_sum;
  logic [10:0] w_x_fwd;
  logic        w_overlap;
  logic [9:0]  w_spawn_x;
  logic        w_spawn_dir;

`ifdef FOLLOWER_LANE_LFSR_EN
  logic [9:0] r_lfsr;

  // Fibonacci form of x^10 + x^7 + 1
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
  end

  // The LFSR never exceeds 1023, so one subtraction lands inside the track.
  assign w_spawn_x   = (r_lfsr <= c_x_max) ? r_lfsr : r_lfsr - c_x_max;
  assign w_spawn_dir = r_lfsr[0];
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_spawn_x     = '0;
  assign w_spawn_dir   = 1'b1;
`endif

  assign w_lane_sum = {1'b0, r_lane_y} + c_move;
  assign w_x_fwd    = {1'b0, r_car_x} + {1'b0, c_speed};

  assign w_overlap = ({1'b0, player_x} < ({1'b0, r_car_x} + c_car_w)) &&
                     ({1'b0, r_car_x}  < ({1'b0, player_x} + c_ply_w)) &&
                     ({1'b0, player_y} < ({1'b0, r_lane_y} + c_car_h)) &&
                     ({1'b0, r_lane_y} < ({1'b0, player_y} + c_ply_h));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_lane_y    <= c_init_y;
      r_car_x     <= '0;
      r_car_dir   <= 1'b1;
      r_respawned <= 1'b0;
      r_hit       <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane_y    <= w_lane_y_nxt;
      r_car_x     <= w_car_x_nxt;
      r_car_dir   <= w_car_dir_nxt;
      r_respawned <= w_respawned_nxt;
      r_hit       <= w_hit_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lane_y_nxt    = r_lane_y;
    w_car_x_nxt     = r_car_x;
    w_car_dir_nxt   = r_car_dir;
    w_respawned_nxt = 1'b0;
    w_hit_nxt       = r_hit;
    w_pend_nxt      = r_pend;
    case (r_state)
      ST_RUN: begin
        // A collision freezes the car in place, so it wins over movement.
        if (w_overlap) begin
          w_hit_nxt   = 1'b1;
          w_state_nxt = ST_HIT;
        end else begin
          if (move_followers || r_pend) begin
            w_pend_nxt = 1'b0;
            if (w_lane_sum >= c_height) begin
              w_lane_y_nxt = '0;
              w_state_nxt  = ST_RESPAWN;
            end else begin
              w_lane_y_nxt = w_lane_sum[9:0];
            end
          end
          if (frame_tick) begin
            if (r_car_dir) begin
              if (w_x_fwd >= {1'b0, c_x_max}) begin
                w_car_x_nxt   = c_x_max;
                w_car_dir_nxt = 1'b0;
              end else begin
                w_car_x_nxt = w_x_fwd[9:0];
              end
            end else if (r_car_x <= c_speed) begin
              w_car_x_nxt   = '0;
              w_car_dir_nxt = 1'b1;
            end else begin
              w_car_x_nxt = r_car_x - c_speed;
            end
          end
        end
      end
      ST_RESPAWN: begin
        w_car_x_nxt     = w_spawn_x;
        w_car_dir_nxt   = w_spawn_dir;
        w_respawned_nxt = 1'b1;
        w_state_nxt     = ST_RUN;
        if (move_followers) w_pend_nxt = 1'b1;
      end
      ST_HIT: begin
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign lane_y    = r_lane_y;
  assign car_x     = r_car_x;
  assign car_dir   = r_car_dir;
  assign respawned = r_respawned;
  assign hit       = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_follower_lane.sv
`default_nettype none
// ============================================================================
// Module   : tb_follower_lane
// Brief    : Scoreboard bench for follower_lane: a behavioural model predicts
//            every cycle's outputs, a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_follower_lane;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_followers = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] player_x = '0;
  logic [9:0] player_y = 10'd1000;
  logic [9:0] lane_y;
  logic [9:0] car_x;
  logic       car_dir;
  logic       respawned;
  logic       hit;

  always #20 clk = ~clk;

  follower_lane dut (
    .clk            (clk),
    .reset          (reset),
    .move_followers (move_followers),
    .frame_tick     (frame_tick),
    .player_x       (player_x),
    .player_y       (player_y),
    .lane_y         (lane_y),
    .car_x          (car_x),
    .car_dir        (car_dir),
    .respawned      (respawned),
    .hit            (hit)
  );

  typedef struct {
    int lane;
    int x;
    int dir;
    int resp;
    int hit;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_lane, m_x, m_dir, m_resp, m_hit, m_pend, m_spawning, m_lfsr;

  // Reference model: one call per clock edge, from the rules of the game.
  task automatic model(input bit r, input bit mf, input bit ft, input int px, input int py);
    if (r) begin
      m_lane = 0; m_x = 0; m_dir = 1; m_resp = 0; m_hit = 0;
      m_pend = 0; m_spawning = 0; m_lfsr = 'h2A5;
      return;
    end
    if (m_hit != 0) begin
      m_resp = 0;
    end else if (m_spawning != 0) begin
`ifdef FOLLOWER_LANE_LFSR_EN
      m_x   = (m_lfsr <= 608) ? m_lfsr : m_lfsr - 608;
      m_dir = m_lfsr % 2;
`else
      m_x   = 0;
      m_dir = 1;
`endif
      m_resp = 1;
      m_spawning = 0;
      if (mf) m_pend = 1;
    end else begin
      m_resp = 0;
      if (px < m_x + 32 && m_x < px + 16 && py < m_lane + 16 && m_lane < py + 16) begin
        m_hit = 1;
      end else begin
        if (mf || m_pend != 0) begin
          m_pend = 0;
          if (m_lane + 2 >= 480) begin
            m_lane = 0;
            m_spawning = 1;
          end else begin
            m_lane = m_lane + 2;
          end
        end
        if (ft) begin
          if (m_dir != 0) begin
            if (m_x + 3 >= 608) begin m_x = 608; m_dir = 0; end
            else m_x = m_x + 3;
          end else begin
            if (m_x <= 3) begin m_x = 0; m_dir = 1; end
            else m_x = m_x - 3;
          end
        end
      end
    end
    m_lfsr = ((m_lfsr * 2) + (((m_lfsr / 512) ^ (m_lfsr / 64)) % 2)) % 1024;
  endtask

  task automatic cyc(input bit r, input bit mf, input bit ft, input int px, input int py);
    exp_t e;
    @(negedge clk);
    reset          = r;
    move_followers = mf;
    frame_tick     = ft;
    player_x       = 10'(px);
    player_y       = 10'(py);
    model(r, mf, ft, px, py);
    e.lane = m_lane; e.x = m_x; e.dir = m_dir; e.resp = m_resp; e.hit = m_hit;
    sb.push_back(e);
  endtask

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // Monitor: every clock the DUT presents a fresh set of registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (lane_y !== 10'(e.lane) || car_x !== 10'(e.x) || car_dir !== 1'(e.dir) ||
            respawned !== 1'(e.resp) || hit !== 1'(e.hit)) begin
          miscompares++;
          $display("FAIL outputs @%0t: got lane_y=%0d car_x=%0d dir=%0d resp=%0d hit=%0d, expected lane_y=%0d car_x=%0d dir=%0d resp=%0d hit=%0d",
                   $time, lane_y, car_x, car_dir, respawned, hit,
                   e.lane, e.x, e.dir, e.resp, e.hit);
        end
      end
    end
  end

  initial begin
    model(1'b1, 1'b0, 1'b0, 0, 1000);
    repeat (2) cyc(1, 0, 0, 0, 1000);

    // Spaced steps up to and through the wrap, then idle across respawn.
    for (int i = 0; i < 240; i++) begin
      cyc(0, 1, 0, 0, 1000);
      cyc(0, 0, 0, 0, 1000);
    end
    repeat (3) cyc(0, 0, 0, 0, 1000);

    // Second wrap with a step landing on the respawn cycle.
    cyc(1, 0, 0, 0, 1000);
    for (int i = 0; i < 240; i++) begin
      cyc(0, 1, 0, 0, 1000);
      if (i < 239) cyc(0, 0, 0, 0, 1000);
    end
    cyc(0, 1, 0, 0, 1000);
    repeat (3) cyc(0, 0, 0, 0, 1000);

    // Simultaneous step and tick, then ride the car across both edges.
    cyc(0, 1, 1, 0, 1000);
    for (int i = 0; i < 420; i++) cyc(0, 0, 1, 0, 1000);

    // Edge-touching player, then one pixel of overlap, then frozen pulses.
    repeat (3) cyc(0, 0, 0, clip(m_x + 32), m_lane);
    cyc(0, 0, 0, clip(m_x + 31), m_lane);
    repeat (4) cyc(0, 1, 1, 0, 1000);
    cyc(1, 0, 0, 0, 1000);
    repeat (2) cyc(0, 0, 1, 0, 1000);

    // Randomised play with occasional resets.
    for (int i = 0; i < 5000; i++) begin
      bit r, mf, ft;
      int px, py;
      r  = ($urandom_range(0, 399) == 0) || (m_hit != 0 && $urandom_range(0, 15) == 0);
      mf = ($urandom_range(0, 1) == 0);
      ft = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) begin
        px = clip(m_x + $urandom_range(0, 80) - 40);
        py = clip(m_lane + $urandom_range(0, 48) - 24);
      end else begin
        px = $urandom_range(0, 1023);
        py = 1000;
      end
      cyc(r, mf, ft, px, py);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/follower_lane.md
# follower_lane

Obstacle lane driven by the vertical scroller's `move_followers` step pulse. It holds one car's lane row (`lane_y`) and horizontal position (`car_x`). On each step pulse it scrolls the row down and wraps it at the screen bottom, respawning the car on wrap. Each frame it moves the car horizontally, bouncing at the screen edges, and flags a sticky collision with the player box for the game-over logic.

## Interface
- `MOVE_AMT`, 2: rows scrolled per `move_followers` pulse
- `SCREEN_HEIGHT`, 480: wrap threshold for `lane_y`
- `SCREEN_WIDTH`, 640: horizontal extent
- `INIT_Y`, 0: `lane_y` after reset (must be < `SCREEN_HEIGHT`)
- `CAR_W`, 32 / `CAR_H`, 16: car box size
- `PLAYER_W`, 16 / `PLAYER_H`, 16: player box size
- `CAR_SPEED`, 3: pixels moved per `frame_tick`
- `LFSR_SEED`, 10'h2A5: nonzero LFSR reset value
- `clk` in 1: system clock (25 MHz)
- `reset` in 1: synchronous, active-high
- `move_followers` in 1: one-cycle step pulse from the vertical scroller
- `frame_tick` in 1: one-cycle pulse per video frame
- `player_x` in 10: player box left edge
- `player_y` in 10: player box top edge
- `lane_y` out 10: lane top row, registered
- `car_x` out 10: car left edge, registered
- `car_dir` out 1: 1 = moving right, 0 = moving left
- `respawned` out 1: one-cycle pulse when a new car is placed
- `hit` out 1: sticky collision flag; cleared only by reset

## Operation
- States: RUN, RESPAWN, HIT. Internal registers: a 1-deep `pend` flag and a 10-bit LFSR.
- Reset values: `lane_y`=`INIT_Y`, `car_x`=0, `car_dir`=1, `respawned`=0, `hit`=0, state RUN, `pend`=0, LFSR=`LFSR_SEED`.
- **Vertical step (RUN).** A step occurs on `move_followers` or `pend`. `pend` is cleared when the step is taken.
  - If `lane_y`+`MOVE_AMT` >= `SCREEN_HEIGHT` (11-bit compare): `lane_y` <= 0 and go to RESPAWN.
  - Otherwise: `lane_y` <= `lane_y`+`MOVE_AMT`.
- **Horizontal move (RUN, `frame_tick`).**
  - Right: if `car_x`+`CAR_SPEED` >= `SCREEN_WIDTH`-`CAR_W`, clamp `car_x` to `SCREEN_WIDTH`-`CAR_W` and set `car_dir` to 0. Otherwise add `CAR_SPEED`.
  - Left: if `car_x` <= `CAR_SPEED`, set `car_x` to 0 and `car_dir` to 1. Otherwise subtract `CAR_SPEED`.
- **Same-cycle step and frame tick.** Both updates apply. If the step wraps, the RESPAWN placement overrides the horizontal result on the next cycle.
- **RESPAWN (exactly 1 cycle).**
  - Load `car_x` from the LFSR value L: L if L <= `SCREEN_WIDTH`-`CAR_W`, else L-(`SCREEN_WIDTH`-`CAR_W`). One subtraction suffices.
  - `car_dir` <= L[0]; `respawned` <= 1; return to RUN.
  - A `move_followers` pulse during RESPAWN sets `pend`. A `frame_tick` during RESPAWN is dropped.
- **LFSR.** 10-bit Fibonacci, polynomial x^10+x^7+1. Advances every non-reset clock in all states.
- **Collision (evaluated every RUN cycle).** Overlap exists when all four hold, using 11-bit sums and strict inequalities:
  - `player_x` < `car_x`+`CAR_W`
  - `car_x` < `player_x`+`PLAYER_W`
  - `player_y` < `lane_y`+`CAR_H`
  - `lane_y` < `player_y`+`PLAYER_H`
- On overlap: `hit` <= 1 and go to HIT. Edge-touching boxes do not overlap.
- **HIT.** `lane_y`, `car_x` and `car_dir` are frozen. Step and frame pulses are ignored. Only reset exits.
- **Reset mid-operation.** Reset in any state, including RESPAWN and HIT, restores all reset values on the next edge and discards `pend`.

## Timing
- All outputs are registered. Step or frame update is visible 1 cycle after the input pulse.
- Wrap sequence:
  - Pulse at cycle N → `lane_y`=0 at N+1.
  - At N+2: new `car_x` and `car_dir` appear, with `respawned`=1 for that single cycle.
- Pending step: a pulse during RESPAWN is applied at the first RUN cycle, so `lane_y`=`MOVE_AMT` one cycle later.
- `hit` rises 1 cycle after overlapping positions are present on the registered outputs and player inputs.
- Minimum pulse spacing: none required. Back-to-back `move_followers` pulses are each applied, except that two pulses during one RESPAWN cycle cannot occur (RESPAWN lasts 1 cycle).

## Configuration
- `FOLLOWER_LANE_LFSR_EN` defined: respawn position and direction come from the LFSR as above.
- `FOLLOWER_LANE_LFSR_EN` undefined:
  - The LFSR is removed and `LFSR_SEED` is unused.
  - RESPAWN loads `car_x`=0 and `car_dir`=1.
  - All other behaviour, including the 1-cycle RESPAWN, `respawned` and `pend`, is unchanged.

## Test plan
- **Wrap and respawn.** Reset, then 240 spaced `move_followers` pulses (`MOVE_AMT`=2) → `lane_y`=478 after pulse 239. Pulse 240 → `lane_y`=0, then `respawned`=1 for one cycle; `car_x` <= 608.
- **Right-edge bounce.** `car_x`=606, `car_dir`=1, `frame_tick` → `car_x`=608, `car_dir`=0. Next tick → 605. Left edge: `car_x`=3, dir 0, tick → 0, dir 1.
- **Collision.**
  - `player_x`=`car_x`+31, `player_y`=`lane_y` → `hit`=1 next cycle; further ticks and pulses leave `car_x`/`lane_y` frozen.
  - `player_x`=`car_x`+32 → `hit` stays 0.
- **Simultaneous pulses.** `move_followers` and `frame_tick` in the same cycle from `lane_y`=10, `car_x`=100, dir 1 → `lane_y`=12, `car_x`=103.
- **Step during RESPAWN.** `move_followers` asserted on the RESPAWN cycle → `pend` set; `lane_y`=2 two cycles later.
- **Reset from HIT.** Assert `reset` for 1 cycle while in HIT → `hit`=0, `lane_y`=`INIT_Y`, `car_x`=0, `car_dir`=1 next cycle; LFSR=`LFSR_SEED`.
